// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM stage and its data memory.
//   mem_size_e : access-size encodings as carried on MemSize_in_MEMWB
//   DEPTH_DEF  : default data-memory depth in 32-bit words
//   lane_mask(): byte-write-enable mask for a size and (aligned) byte offset
package mem_pkg;

  localparam int DEPTH_DEF = 1024;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11   // behaves as a word access
  } mem_size_e;

  // Little-endian lane mask; bit k enables byte k of the 32-bit word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: return 4'b0001 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_bytelane.sv
// data_mem_bytelane: DEPTH x 32 data RAM built from four byte-wide lanes.
// Synchronous read with read-before-write: a read and write to the same index
// in one cycle return the old contents. Contents are never reset.
//   i_clk   : clock, rising edge
//   i_re    : read enable; o_rdata holds its value while low
//   i_we    : per-byte write enable
//   i_addr  : word index
//   i_wdata : write data (lanes already replicated by the caller)
//   o_rdata : registered read data
module data_mem_bytelane
  import mem_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_re,
  input  logic [3:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    always_ff @(posedge i_clk) begin
      if (i_we[g]) r_mem[i_addr] <= i_wdata[8*g +: 8];
      if (i_re)    r_q           <= r_mem[i_addr];
    end

    assign o_rdata[8*g +: 8] = r_q;
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage (branch resolve, data-memory access) and the MEM/WB
// pipeline register feeding writeback.
// Optional build macro: MEMWB_MISALIGN_TRAP_EN
//   defined   : misaligned word/half accesses are flagged on Misalign_out_MEMWB,
//               stores suppressed, loads do not write the register file
//   undefined : low address bits are forced aligned and the access proceeds
// Ports:
//   Clk/Rst          : clock, synchronous active-high reset
//   MemWrite/MemRead : store / load enables; MemSize, MemSigned select width/extension
//   ALUResult        : byte address for memory, also passed to WB
//   ReadData2        : store data
//   Branch/Zero/ALUAddResult -> PCSrc/BranchTarget (combinational)
//   Stall/Flush      : hold / bubble the MEM/WB register
//   *_out (except PCSrc/BranchTarget) : registered WB bundle
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 10
) (
  input  logic        Clk_in_MEMWB,
  input  logic        Rst_in_MEMWB,
  input  logic        MemWrite_in_MEMWB,
  input  logic        MemRead_in_MEMWB,
  input  logic        Branch_in_MEMWB,
  input  logic        MemtoReg_in_MEMWB,
  input  logic        RegWrite_in_MEMWB,
  input  logic [31:0] ALUAddResult_in_MEMWB,
  input  logic        Zero_in_MEMWB,
  input  logic [31:0] ALUResult_in_MEMWB,
  input  logic [31:0] ReadData2_in_MEMWB,
  input  logic [4:0]  WriteReg_in_MEMWB,
  input  logic [1:0]  MemSize_in_MEMWB,
  input  logic        MemSigned_in_MEMWB,
  input  logic        Stall_in_MEMWB,
  input  logic        Flush_in_MEMWB,
  output logic        PCSrc_out_MEMWB,
  output logic [31:0] BranchTarget_out_MEMWB,
  output logic        MemtoReg_out_MEMWB,
  output logic        RegWrite_out_MEMWB,
  output logic [31:0] ReadData_out_MEMWB,
  output logic [31:0] ALUResult_out_MEMWB,
  output logic [4:0]  WriteReg_out_MEMWB
`ifdef MEMWB_MISALIGN_TRAP_EN
  ,
  output logic        Misalign_out_MEMWB
`endif
);

  // Branch resolution is independent of the pipeline register.
  assign PCSrc_out_MEMWB        = Branch_in_MEMWB & Zero_in_MEMWB;
  assign BranchTarget_out_MEMWB = ALUAddResult_in_MEMWB;

  logic [1:0]        w_off;
  logic [1:0]        w_off_al;
  logic [ADDR_W-1:0] w_idx;
  logic              w_adv;
  logic              w_st_ok;
  logic              w_rw;
  logic [3:0]        w_we;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rdata;

  assign w_off = ALUResult_in_MEMWB[1:0];
  assign w_idx = ALUResult_in_MEMWB[ADDR_W+1:2];  // upper bits dropped: index wraps
  assign w_adv = !Rst_in_MEMWB && !Stall_in_MEMWB && !Flush_in_MEMWB;

  // Aligned offset used for lane selection in both builds.
  always_comb begin
    w_off_al = w_off;
    case (MemSize_in_MEMWB)
      SZ_HALF: w_off_al = {w_off[1], 1'b0};
      SZ_BYTE: w_off_al = w_off;
      default: w_off_al = 2'b00;
    endcase
  end

  always_comb begin
    w_wdata = ReadData2_in_MEMWB;
    case (MemSize_in_MEMWB)
      SZ_HALF: w_wdata = {2{ReadData2_in_MEMWB[15:0]}};
      SZ_BYTE: w_wdata = {4{ReadData2_in_MEMWB[7:0]}};
      default: w_wdata = ReadData2_in_MEMWB;
    endcase
  end

`ifdef MEMWB_MISALIGN_TRAP_EN
  logic w_mis;
  always_comb begin
    w_mis = 1'b0;
    if (MemRead_in_MEMWB || MemWrite_in_MEMWB) begin
      case (MemSize_in_MEMWB)
        SZ_HALF: w_mis = w_off[0];
        SZ_BYTE: w_mis = 1'b0;
        default: w_mis = (w_off != 2'b00);
      endcase
    end
  end
  assign w_st_ok = MemWrite_in_MEMWB && w_adv && !w_mis;
  assign w_rw    = RegWrite_in_MEMWB && !(w_mis && MemRead_in_MEMWB);
`else
  assign w_st_ok = MemWrite_in_MEMWB && w_adv;
  assign w_rw    = RegWrite_in_MEMWB;
`endif

  assign w_we = w_st_ok ? lane_mask(MemSize_in_MEMWB, w_off_al) : 4'b0000;

  // RAM read register only advances with the pipeline, so on Stall it holds
  // alongside the rest of the MEM/WB bundle.
  data_mem_bytelane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dmem (
    .i_clk   (Clk_in_MEMWB),
    .i_re    (w_adv),
    .i_we    (w_we),
    .i_addr  (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // MEM/WB register. Load lane/size/sign are registered so extension can be
  // applied to the RAM's registered word on the WB side.
  logic        r_m2r, r_rw, r_rd_en, r_sgn;
  logic [31:0] r_alu;
  logic [4:0]  r_wreg;
  logic [1:0]  r_off, r_size;

  always_ff @(posedge Clk_in_MEMWB) begin
    if (Rst_in_MEMWB || Flush_in_MEMWB) begin
      r_m2r   <= 1'b0;
      r_rw    <= 1'b0;
      r_rd_en <= 1'b0;
      r_sgn   <= 1'b0;
      r_alu   <= '0;
      r_wreg  <= '0;
      r_off   <= '0;
      r_size  <= '0;
    end else if (!Stall_in_MEMWB) begin
      r_m2r   <= MemtoReg_in_MEMWB;
      r_rw    <= w_rw;
      r_rd_en <= MemRead_in_MEMWB;
      r_sgn   <= MemSigned_in_MEMWB;
      r_alu   <= ALUResult_in_MEMWB;
      r_wreg  <= WriteReg_in_MEMWB;
      r_off   <= w_off_al;
      r_size  <= MemSize_in_MEMWB;
    end
  end

`ifdef MEMWB_MISALIGN_TRAP_EN
  logic r_mis;
  always_ff @(posedge Clk_in_MEMWB) begin
    if (Rst_in_MEMWB || Flush_in_MEMWB) r_mis <= 1'b0;
    else if (!Stall_in_MEMWB)           r_mis <= w_mis;
  end
  assign Misalign_out_MEMWB = r_mis;
`endif

  logic [31:0] w_sh;
  logic [31:0] w_ext;
  assign w_sh = w_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ext = w_sh;
    case (r_size)
      SZ_HALF: w_ext = {{16{r_sgn & w_sh[15]}}, w_sh[15:0]};
      SZ_BYTE: w_ext = {{24{r_sgn & w_sh[7]}},  w_sh[7:0]};
      default: w_ext = w_sh;
    endcase
  end

  assign MemtoReg_out_MEMWB  = r_m2r;
  assign RegWrite_out_MEMWB  = r_rw;
  assign ReadData_out_MEMWB  = r_rd_en ? w_ext : 32'h0;
  assign ALUResult_out_MEMWB = r_alu;
  assign WriteReg_out_MEMWB  = r_wreg;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
  import mem_pkg::*;

  logic        Clk_in_MEMWB = 1'b0;
  logic        Rst_in_MEMWB, MemWrite_in_MEMWB, MemRead_in_MEMWB, Branch_in_MEMWB;
  logic        MemtoReg_in_MEMWB, RegWrite_in_MEMWB, Zero_in_MEMWB, MemSigned_in_MEMWB;
  logic        Stall_in_MEMWB, Flush_in_MEMWB;
  logic [31:0] ALUAddResult_in_MEMWB, ALUResult_in_MEMWB, ReadData2_in_MEMWB;
  logic [4:0]  WriteReg_in_MEMWB;
  logic [1:0]  MemSize_in_MEMWB;
  logic        PCSrc_out_MEMWB, MemtoReg_out_MEMWB, RegWrite_out_MEMWB;
  logic [31:0] BranchTarget_out_MEMWB, ReadData_out_MEMWB, ALUResult_out_MEMWB;
  logic [4:0]  WriteReg_out_MEMWB;
`ifdef MEMWB_MISALIGN_TRAP_EN
  logic        Misalign_out_MEMWB;
`endif

  always #5 Clk_in_MEMWB = ~Clk_in_MEMWB;

  mem_wb_stage #(.DEPTH(1024), .ADDR_W(10)) dut (
    .Clk_in_MEMWB(Clk_in_MEMWB), .Rst_in_MEMWB(Rst_in_MEMWB),
    .MemWrite_in_MEMWB(MemWrite_in_MEMWB), .MemRead_in_MEMWB(MemRead_in_MEMWB),
    .Branch_in_MEMWB(Branch_in_MEMWB), .MemtoReg_in_MEMWB(MemtoReg_in_MEMWB),
    .RegWrite_in_MEMWB(RegWrite_in_MEMWB), .ALUAddResult_in_MEMWB(ALUAddResult_in_MEMWB),
    .Zero_in_MEMWB(Zero_in_MEMWB), .ALUResult_in_MEMWB(ALUResult_in_MEMWB),
    .ReadData2_in_MEMWB(ReadData2_in_MEMWB), .WriteReg_in_MEMWB(WriteReg_in_MEMWB),
    .MemSize_in_MEMWB(MemSize_in_MEMWB), .MemSigned_in_MEMWB(MemSigned_in_MEMWB),
    .Stall_in_MEMWB(Stall_in_MEMWB), .Flush_in_MEMWB(Flush_in_MEMWB),
    .PCSrc_out_MEMWB(PCSrc_out_MEMWB), .BranchTarget_out_MEMWB(BranchTarget_out_MEMWB),
    .MemtoReg_out_MEMWB(MemtoReg_out_MEMWB), .RegWrite_out_MEMWB(RegWrite_out_MEMWB),
    .ReadData_out_MEMWB(ReadData_out_MEMWB), .ALUResult_out_MEMWB(ALUResult_out_MEMWB),
    .WriteReg_out_MEMWB(WriteReg_out_MEMWB)
`ifdef MEMWB_MISALIGN_TRAP_EN
    , .Misalign_out_MEMWB(Misalign_out_MEMWB)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-addressed reference memory covering DEPTH*4 bytes.
  logic [7:0] mdl [4096];

  typedef struct {
    logic        rw, m2r, mis;
    logic [31:0] rd, alu;
    logic [4:0]  wr;
  } exp_t;

  exp_t sb[$];
  exp_t last;

  task automatic step(input string tag, input logic mw, input logic mr, input logic rw,
                      input logic m2r, input logic [31:0] addr, input logic [31:0] rd2,
                      input logic [4:0] wr, input logic [1:0] sz, input logic sgn,
                      input logic stall, input logic flush, input logic rst);
    exp_t        e;
    logic [1:0]  offa;
    logic [11:0] b;
    logic [31:0] w, sh, val;
    logic        mis, trap;
    MemWrite_in_MEMWB  = mw;   MemRead_in_MEMWB   = mr;
    RegWrite_in_MEMWB  = rw;   MemtoReg_in_MEMWB  = m2r;
    ALUResult_in_MEMWB = addr; ReadData2_in_MEMWB = rd2;
    WriteReg_in_MEMWB  = wr;   MemSize_in_MEMWB   = sz;
    MemSigned_in_MEMWB = sgn;  Stall_in_MEMWB     = stall;
    Flush_in_MEMWB     = flush; Rst_in_MEMWB      = rst;

    mis = (mr || mw) && (((sz == 2'b00 || sz == 2'b11) && addr[1:0] != 2'b00) ||
                         (sz == 2'b01 && addr[0]));
`ifdef MEMWB_MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    offa = (sz == 2'b10) ? addr[1:0] : (sz == 2'b01) ? {addr[1], 1'b0} : 2'b00;
    b    = {addr[11:2], 2'b00};
    w    = {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
    sh   = w >> (8 * offa);
    if (sz == 2'b10)      val = sgn ? {{24{sh[7]}}, sh[7:0]}   : {24'h0, sh[7:0]};
    else if (sz == 2'b01) val = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
    else                  val = sh;

    if (rst || flush) e = '{rw: 1'b0, m2r: 1'b0, mis: 1'b0, rd: 32'h0, alu: 32'h0, wr: 5'h0};
    else if (stall)   e = last;
    else e = '{rw: rw && !(trap && mr), m2r: m2r, mis: trap, rd: mr ? val : 32'h0,
               alu: addr, wr: wr};

    // Store applied to the model after the read: read-before-write.
    if (mw && !rst && !stall && !flush && !trap) begin
      if (sz == 2'b10)      mdl[b + 12'(offa)] = rd2[7:0];
      else if (sz == 2'b01) begin
        mdl[b + 12'(offa)]     = rd2[7:0];
        mdl[b + 12'(offa) + 1] = rd2[15:8];
      end else
        for (int k = 0; k < 4; k++) mdl[b + 12'(k)] = rd2[8*k +: 8];
    end

    sb.push_back(e);
    last = e;
    @(posedge Clk_in_MEMWB);
    #1;
    e = sb.pop_front();
    chk({tag, ".rw"},  {31'h0, RegWrite_out_MEMWB}, {31'h0, e.rw});
    chk({tag, ".m2r"}, {31'h0, MemtoReg_out_MEMWB}, {31'h0, e.m2r});
    chk({tag, ".rd"},  ReadData_out_MEMWB, e.rd);
    chk({tag, ".alu"}, ALUResult_out_MEMWB, e.alu);
    chk({tag, ".wr"},  {27'h0, WriteReg_out_MEMWB}, {27'h0, e.wr});
`ifdef MEMWB_MISALIGN_TRAP_EN
    chk({tag, ".mis"}, {31'h0, Misalign_out_MEMWB}, {31'h0, e.mis});
`endif
  endtask

  task automatic br_chk(input string tag, input logic br, input logic z,
                        input logic [31:0] tgt, input logic exp_pc);
    Branch_in_MEMWB = br; Zero_in_MEMWB = z; ALUAddResult_in_MEMWB = tgt;
    #1;
    chk({tag, ".pcsrc"}, {31'h0, PCSrc_out_MEMWB}, {31'h0, exp_pc});
    chk({tag, ".tgt"},   BranchTarget_out_MEMWB, tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mdl[i] = 8'h00;
    Branch_in_MEMWB = 1'b0; Zero_in_MEMWB = 1'b0; ALUAddResult_in_MEMWB = 32'h0;
    @(negedge Clk_in_MEMWB);

    // Reset: registered outputs cleared, branch path still live.
    step("rst", 1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h55, 5'd3, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst.rd0", ReadData_out_MEMWB, 32'h0);
    chk("rst.rw0", {31'h0, RegWrite_out_MEMWB}, 32'h0);
    Rst_in_MEMWB = 1'b1;
    br_chk("br_rst", 1'b1, 1'b1, 32'h100, 1'b1);

    step("st_w10", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ld_b13", 1'b0, 1'b1, 1'b1, 1'b1, 32'h13, 32'h0, 5'd5, SZ_BYTE, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ld_b13.const", ReadData_out_MEMWB, 32'hFFFFFFDE);

    step("st_w20", 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h12345678, 5'd0, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0);
    step("st_h22", 1'b1, 1'b0, 1'b0, 1'b0, 32'h22, 32'hAAAA8001, 5'd0, SZ_HALF, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ld_hu22", 1'b0, 1'b1, 1'b1, 1'b1, 32'h22, 32'h0, 5'd6, SZ_HALF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ld_hu22.const", ReadData_out_MEMWB, 32'h00008001);
    step("ld_hs22", 1'b0, 1'b1, 1'b1, 1'b1, 32'h22, 32'h0, 5'd6, SZ_HALF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ld_hs22.const", ReadData_out_MEMWB, 32'hFFFF8001);
    step("ld_w20", 1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h0, 5'd7, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ld_w20.const", ReadData_out_MEMWB, 32'h80015678);

    // Non-load op: ReadData must be 0.
    step("alu", 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234, 32'h0, 5'd9, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("alu.rd0", ReadData_out_MEMWB, 32'h0);

    // Stalled store is not written; a released one is.
    step("st_w40z", 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 5'd0, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0);
    step("st40_stall_a", 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h5, 5'd1, SZ_WORD, 1'b0, 1'b1, 1'b0, 1'b0);
    step("st40_stall_b", 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h5, 5'd1, SZ_WORD, 1'b0, 1'b1, 1'b0, 1'b0);
    step("ld40_nost", 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0, 5'd2, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ld40_nost.const", ReadData_out_MEMWB, 32'h0);
    step("st40_stall_c", 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h5, 5'd0, SZ_WORD, 1'b0, 1'b1, 1'b0, 1'b0);
    step("st40_rel", 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h5, 5'd0, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ld40", 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0, 5'd2, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ld40.const", ReadData_out_MEMWB, 32'h5);

    // Flush wins over Stall; flushed store is dropped.
    step("fl_stall", 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd7, SZ_WORD, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("fl_stall.rw0", {31'h0, RegWrite_out_MEMWB}, 32'h0);
    step("st40_fl", 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h77, 5'd0, SZ_WORD, 1'b0, 1'b0, 1'b1, 1'b0);
    step("ld40_b", 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0, 5'd2, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ld40_b.const", ReadData_out_MEMWB, 32'h5);

    // Read-before-write.
    step("rbw", 1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h9, 5'd4, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rbw.const", ReadData_out_MEMWB, 32'h5);
    step("ld40_c", 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0, 5'd4, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ld40_c.const", ReadData_out_MEMWB, 32'h9);

    // Branch path combinational, also while stalled/flushed.
    Stall_in_MEMWB = 1'b1; Flush_in_MEMWB = 1'b1;
    br_chk("br_taken", 1'b1, 1'b1, 32'h100, 1'b1);
    br_chk("br_nz", 1'b1, 1'b0, 32'h100, 1'b0);
    br_chk("br_nb", 1'b0, 1'b1, 32'h2468, 1'b0);

    // Index wrap: 0x1000 aliases word 0.
    step("st_wrap", 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000, 32'hCAFEF00D, 5'd0, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ld_w0", 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 5'd8, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ld_w0.const", ReadData_out_MEMWB, 32'hCAFEF00D);

`ifdef MEMWB_MISALIGN_TRAP_EN
    step("mis_w02", 1'b0, 1'b1, 1'b1, 1'b1, 32'h02, 32'h0, 5'd8, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mis_w02.flag", {31'h0, Misalign_out_MEMWB}, 32'h1);
    chk("mis_w02.rw0", {31'h0, RegWrite_out_MEMWB}, 32'h0);
    step("mis_st", 1'b1, 1'b0, 1'b0, 1'b0, 32'h41, 32'h1111, 5'd0, SZ_HALF, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ld40_d", 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0, 5'd4, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ld40_d.const", ReadData_out_MEMWB, 32'h9);
`else
    step("al_w22", 1'b0, 1'b1, 1'b1, 1'b1, 32'h22, 32'h0, 5'd8, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("al_w22.const", ReadData_out_MEMWB, 32'h80015678);
    step("al_h13", 1'b0, 1'b1, 1'b1, 1'b1, 32'h13, 32'h0, 5'd8, SZ_HALF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("al_h13.const", ReadData_out_MEMWB, 32'h0000DEAD);
`endif

    step("rst2", 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0, 5'd3, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
